// File: rtl/n64_joybus_sniffer.sv
// n64_joybus_sniffer: passive multi-channel N64 joybus sniffer.
// Each channel watches one open-drain CTRL line. It decodes the host command
// and captures the controller response when the command matches CMD_FILTER.
// The last response is presented with a sticky valid flag that ACK clears,
// together with a sticky overrun flag and a button-combo (in-game reset)
// detector.
//
// Handshake: DATA_VALID[c] rises on the cycle after a frame commits and stays
// high until ACK[c] is seen on a clock edge with no commit on that same edge.
// CTRL_DATA holds the committed word until the next commit. If a commit and
// ACK land on the same edge, the new frame wins: DATA_VALID stays set and
// OVERRUN records whether the previous frame was still unconsumed.
// DBG_STATE exposes each channel's FSM state (3 bits per channel).
module n64_joybus_sniffer #(
  parameter int              NUM_CH     = 1,
  parameter int              CNT_W      = 6,
  parameter logic [7:0]      CMD_FILTER = 8'h01,
  parameter int              RESP_BITS  = 32,
  parameter int              STOP_MIN   = 4,
  parameter logic [15:0]     IGR_COMBO  = 16'h3030,
  parameter int              IGR_HOLD   = 3
) (
  input  logic                          CLK_4M,
  input  logic                          SRST,
  input  logic [NUM_CH-1:0]             CTRL,
  input  logic                          IGR_EN,
  input  logic [NUM_CH-1:0]             ACK,
  output logic [NUM_CH*RESP_BITS-1:0]   CTRL_DATA,
  output logic [NUM_CH-1:0]             DATA_VALID,
  output logic [NUM_CH-1:0]             OVERRUN,
  output logic [NUM_CH-1:0]             FRAME_ERR,
  output logic [NUM_CH-1:0]             IGR_TRIG,
  output logic [NUM_CH*3-1:0]           DBG_STATE
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  localparam int              BC_W       = $clog2(RESP_BITS + 1);
  localparam logic [BC_W-1:0] BC_CMD_END = BC_W'(7);
  localparam logic [BC_W-1:0] BC_RSP_END = BC_W'(RESP_BITS - 1);
  localparam logic [CNT_W:0]  STOP_MIN_W = (CNT_W + 1)'(STOP_MIN);
  localparam logic [3:0]      HOLD_V     = 4'(IGR_HOLD);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0]           r_hist;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_low_w;
    logic [2:0]           r_state;
    logic [BC_W-1:0]      r_bitcnt;
    logic [7:0]           r_cmd;
    logic [RESP_BITS-1:0] r_shift;
    logic [RESP_BITS-1:0] r_data;
    logic                 r_dv;
    logic                 r_ovr;
    logic                 r_ferr;
    logic                 r_igr;
    logic [3:0]           r_hold;

    logic                 w_neg;
    logic                 w_pos;
    logic                 w_sat;
    logic                 w_bit;
    logic                 w_stop_ok;
    logic                 w_commit;
    logic [7:0]           w_cmd_next;
    logic [15:0]          w_lo16;

    // Edge detection looks at the two older history taps; the newest tap
    // is the first synchroniser stage for the asynchronous line.
    assign w_neg      = r_hist[2] & ~r_hist[1];
    assign w_pos      = ~r_hist[2] & r_hist[1];
    assign w_sat      = &r_cnt;
    // Low shorter than high means a 1 bit.
    assign w_bit      = (r_low_w < r_cnt);
    // cnt holds (low width - 1) when the stop-bit rising edge is seen.
    assign w_stop_ok  = (({1'b0, r_cnt} + (CNT_W + 1)'(1)) >= STOP_MIN_W);
    assign w_cmd_next = {r_cmd[6:0], w_bit};
    assign w_commit   = (r_state == S_STOP) && !w_sat && w_pos && w_stop_ok;

    if (RESP_BITS >= 16) begin : g_lo_full
      assign w_lo16 = r_shift[15:0];
    end else begin : g_lo_ext
      assign w_lo16 = 16'(r_shift);
    end

    // Shift the raw line into the 3-bit history.
    always_ff @(posedge CLK_4M or posedge SRST) begin
      if (SRST) begin
        r_hist <= 3'b111;
      end else begin
        r_hist <= {r_hist[1:0], CTRL[c]};
      end
    end

    // Edge-interval counter (saturating) and latched low width.
    always_ff @(posedge CLK_4M or posedge SRST) begin
      if (SRST) begin
        r_cnt   <= '0;
        r_low_w <= '0;
      end else begin
        if (w_neg || w_pos) begin
          r_cnt <= '0;
        end else if (!w_sat) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_pos) begin
          r_low_w <= r_cnt;
        end
      end
    end

    // Frame FSM: command decode, filter, response shift-in, stop check.
    always_ff @(posedge CLK_4M or posedge SRST) begin
      if (SRST) begin
        r_state  <= S_IDLE;
        r_bitcnt <= '0;
        r_cmd    <= '0;
        r_shift  <= '0;
        r_ferr   <= 1'b0;
      end else begin
        r_ferr <= 1'b0;
        if ((r_state != S_IDLE) && w_sat) begin
          // Line stuck for a full idle interval mid-frame: silent abort.
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_neg && w_sat) begin
                r_state  <= S_CMD;
                r_bitcnt <= '0;
                r_shift  <= '0;
                r_cmd    <= '0;
              end
            end
            S_CMD: begin
              if (w_neg) begin
                // A command bit is decided at the falling edge that ends it,
                // so the eighth bit lands on the host stop-bit falling edge;
                // the filter decision is made on that same edge.
                r_cmd    <= w_cmd_next;
                r_bitcnt <= r_bitcnt + BC_W'(1);
                if (r_bitcnt == BC_CMD_END) begin
                  r_state <= (w_cmd_next == CMD_FILTER) ? S_GAP : S_IDLE;
                end
              end
            end
            S_GAP: begin
              // This falling edge starts response bit 0; nothing to decide.
              if (w_neg) begin
                r_state  <= S_RESP;
                r_bitcnt <= '0;
              end
            end
            S_RESP: begin
              if (w_neg) begin
                r_shift  <= {w_bit, r_shift[RESP_BITS-1:1]};
                r_bitcnt <= r_bitcnt + BC_W'(1);
                if (r_bitcnt == BC_RSP_END) begin
                  r_state <= S_STOP;
                end
              end
            end
            S_STOP: begin
              if (w_pos) begin
                r_state <= S_IDLE;
                if (!w_stop_ok) begin
                  r_ferr <= 1'b1;
                end
              end else if (w_neg) begin
                r_state <= S_IDLE;
                r_ferr  <= 1'b1;
              end
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end

    // Output word, sticky valid and overrun with ACK handshake.
    always_ff @(posedge CLK_4M or posedge SRST) begin
      if (SRST) begin
        r_data <= '0;
        r_dv   <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (w_commit) begin
        r_data <= r_shift;
        r_dv   <= 1'b1;
        r_ovr  <= (r_ovr & ~ACK[c]) | r_dv;
      end else if (ACK[c]) begin
        r_dv  <= 1'b0;
        r_ovr <= 1'b0;
      end
    end

    // In-game-reset combo: count consecutive matching commits.
    always_ff @(posedge CLK_4M or posedge SRST) begin
      if (SRST) begin
        r_hold <= '0;
        r_igr  <= 1'b0;
      end else begin
        r_igr <= 1'b0;
        if (w_commit) begin
          if (!IGR_EN) begin
            r_hold <= '0;
          end else if (w_lo16 == IGR_COMBO) begin
            if (r_hold != HOLD_V) begin
              r_hold <= r_hold + 4'd1;
              if ((r_hold + 4'd1) == HOLD_V) begin
                r_igr <= 1'b1;
              end
            end
          end else begin
            r_hold <= '0;
          end
        end
      end
    end

    assign CTRL_DATA[c*RESP_BITS +: RESP_BITS] = r_data;
    assign DATA_VALID[c]                       = r_dv;
    assign OVERRUN[c]                          = r_ovr;
    assign FRAME_ERR[c]                        = r_ferr;
    assign IGR_TRIG[c]                         = r_igr;
    assign DBG_STATE[c*3 +: 3]                 = r_state;
  end

endmodule

// File: tb/tb_n64_joybus_sniffer.sv
// Testbench for n64_joybus_sniffer: per-channel line waveforms are built in
// arrays, then played one sample per clock; a monitor compares every commit
// against an expected queue.
`timescale 1ns/1ps
module tb_n64_joybus_sniffer;

  localparam int          NUM_CH   = 4;
  localparam int          RB       = 32;
  localparam int          WMAX     = 2048;
  localparam int          EW       = RB + 3;
  localparam int          IGR_HOLD = 3;
  localparam logic [15:0] COMBO    = 16'h3030;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #125 clk = ~clk;

  logic                     srst;
  logic [NUM_CH-1:0]        ctrl;
  logic                     igr_en;
  logic [NUM_CH-1:0]        ack;
  logic [NUM_CH*RB-1:0]     ctrl_data;
  logic [NUM_CH-1:0]        data_valid;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH-1:0]        frame_err;
  logic [NUM_CH-1:0]        igr_trig;
  logic [NUM_CH*3-1:0]      dbg_state;

  n64_joybus_sniffer #(
    .NUM_CH(NUM_CH), .CNT_W(6), .CMD_FILTER(8'h01), .RESP_BITS(RB),
    .STOP_MIN(4), .IGR_COMBO(COMBO), .IGR_HOLD(IGR_HOLD)
  ) dut (
    .CLK_4M(clk), .SRST(srst), .CTRL(ctrl), .IGR_EN(igr_en), .ACK(ack),
    .CTRL_DATA(ctrl_data), .DATA_VALID(data_valid), .OVERRUN(overrun),
    .FRAME_ERR(frame_err), .IGR_TRIG(igr_trig), .DBG_STATE(dbg_state)
  );

  // ---------------- stimulus storage / scoreboard ----------------
  logic          wave [NUM_CH][WMAX];
  logic          ackw [NUM_CH][WMAX];
  int            wlen [NUM_CH];
  logic [EW-1:0] exp_q[$];   // {channel[1:0], igr, data}
  int            n_checks = 0;
  int            n_pass   = 0;
  int            fe_cnt   [NUM_CH];
  int            igr_cnt  [NUM_CH];
  int            commit_at[NUM_CH];
  int            hold_m   [NUM_CH];
  logic [RB-1:0] prev_data[NUM_CH];
  logic          prev_dv  [NUM_CH];

  // ---------------- driver tasks ----------------
  task automatic add(input int c, input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      if (wlen[c] < WMAX) begin
        wave[c][wlen[c]] = lvl;
        ackw[c][wlen[c]] = 1'b0;
        wlen[c]++;
      end
    end
  endtask

  // 4 us bit cell at 4 MHz: 0 = 3 us low / 1 us high, 1 = 1 us low / 3 us high
  task automatic add_bit(input int c, input logic b);
    if (b) begin add(c, 1'b0, 4);  add(c, 1'b1, 12); end
    else   begin add(c, 1'b0, 12); add(c, 1'b1, 4);  end
  endtask

  task automatic add_cmd(input int c, input logic [7:0] cmd);
    add(c, 1'b1, 80);                       // 20 us idle
    for (int i = 7; i >= 0; i--) add_bit(c, cmd[i]);
    add(c, 1'b0, 4);                        // host stop bit
    add(c, 1'b1, 8);                        // turnaround gap
  endtask

  // Full frame; rise returns the index where the controller stop bit ends.
  task automatic build_frame(input int c, input logic [7:0] cmd, input logic [RB-1:0] resp,
                             input int stop_low, output int rise);
    add_cmd(c, cmd);
    for (int i = 0; i < RB; i++) add_bit(c, resp[i]);
    add(c, 1'b0, stop_low);
    rise = wlen[c];
    add(c, 1'b1, 8);
  endtask

  // Push an expected commit, modelling the combo hold counter.
  task automatic expect_commit(input int c, input logic [RB-1:0] d);
    logic t;
    t = 1'b0;
    if (!igr_en) hold_m[c] = 0;
    else if (d[15:0] == COMBO) begin
      if (hold_m[c] < IGR_HOLD) begin
        hold_m[c]++;
        t = (hold_m[c] == IGR_HOLD);
      end
    end else hold_m[c] = 0;
    exp_q.push_back({2'(c), t, d});
  endtask

  // Monitor one sample: detect commits and compare with the scoreboard.
  task automatic mon_step(input int i);
    logic [RB-1:0] d;
    logic [EW-1:0] e;
    logic          com;
    int            idx;
    for (int c = 0; c < NUM_CH; c++) begin
      d = ctrl_data[c*RB +: RB];
      if (frame_err[c]) fe_cnt[c]++;
      if (igr_trig[c])  igr_cnt[c]++;
      com = (data_valid[c] && !prev_dv[c]) || (d !== prev_data[c]);
      if (com) begin
        commit_at[c] = i;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (idx < 0 && exp_q[j][RB+2:RB+1] == 2'(c)) idx = j;
        n_checks++;
        if (idx < 0) begin
          $display("FAIL unexpected_commit ch%0d: got data %h, expected no commit", c, d);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          if (d !== e[RB-1:0] || igr_trig[c] !== e[RB])
            $display("FAIL commit ch%0d: got data %h igr %b, expected data %h igr %b",
                     c, d, igr_trig[c], e[RB-1:0], e[RB]);
          else n_pass++;
        end
      end else if (igr_trig[c]) begin
        n_checks++;
        $display("FAIL igr_no_commit ch%0d: got igr 1, expected 0", c);
      end
      prev_dv[c]   = data_valid[c];
      prev_data[c] = d;
    end
  endtask

  // Play built waveforms, one sample per clock, up to limit samples.
  task automatic play(input int limit);
    int n;
    int full;
    full = 0;
    for (int c = 0; c < NUM_CH; c++) if (wlen[c] > full) full = wlen[c];
    n = (limit < full) ? limit : full;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon_step(i);
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl[c] = (i < wlen[c]) ? wave[c][i] : 1'b1;
        ack[c]  = (i < wlen[c]) ? ackw[c][i] : 1'b0;
      end
    end
    ctrl = '1;
    ack  = '0;
    if (n == full) begin
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        mon_step(n + j);
      end
    end
    for (int c = 0; c < NUM_CH; c++) wlen[c] = 0;
  endtask

  task automatic ack_pulse(input logic [NUM_CH-1:0] m);
    @(negedge clk); mon_step(0); ack = m;
    @(negedge clk); mon_step(0); ack = '0;
    @(negedge clk); mon_step(0);
  endtask

  task automatic check_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s: got %0d pending commits, expected 0", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks++;
    if (ctrl_data !== '0) $display("FAIL %s_data: got %h, expected 0", name, ctrl_data);
    else n_pass++;
    n_checks++;
    if (data_valid !== '0 || overrun !== '0)
      $display("FAIL %s_flags: got dv %b ovr %b, expected 0 0", name, data_valid, overrun);
    else n_pass++;
    n_checks++;
    if (frame_err !== '0 || igr_trig !== '0)
      $display("FAIL %s_pulses: got ferr %b igr %b, expected 0 0", name, frame_err, igr_trig);
    else n_pass++;
    n_checks++;
    if (dbg_state !== '0) $display("FAIL %s_state: got %h, expected 0", name, dbg_state);
    else n_pass++;
  endtask

  task automatic clear_prev();
    for (int c = 0; c < NUM_CH; c++) begin
      prev_data[c] = '0;
      prev_dv[c]   = 1'b0;
      hold_m[c]    = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    srst = 1'b1; ctrl = '1; ack = '0; igr_en = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wlen[c] = 0; fe_cnt[c] = 0; igr_cnt[c] = 0; commit_at[c] = -1;
    end
    clear_prev();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    srst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("post_reset");
  endtask

  task automatic test_basic();
    int k;
    int fe0;
    fe0 = fe_cnt[0];
    commit_at[0] = -1;
    build_frame(0, 8'h01, 32'h00FF8010, 8, k);
    expect_commit(0, 32'h00FF8010);
    play(WMAX);
    check_empty("basic_commit");
    // line rise sampled at k, detected two syncs later, valid one cycle after
    n_checks++;
    if (commit_at[0] != k + 3)
      $display("FAIL basic_latency: got sample %0d, expected %0d", commit_at[0], k + 3);
    else n_pass++;
    n_checks++;
    if (fe_cnt[0] != fe0) $display("FAIL basic_ferr: got %0d pulses, expected 0", fe_cnt[0] - fe0);
    else n_pass++;
    n_checks++;
    if (data_valid[0] !== 1'b1 || ctrl_data[31:0] !== 32'h00FF8010)
      $display("FAIL basic_out: got dv %b data %h, expected 1 00ff8010", data_valid[0], ctrl_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_filter();
    int k;
    ack_pulse(4'b0001);
    build_frame(0, 8'h00, 32'hDEADBEEF, 8, k);
    play(WMAX);
    check_empty("filter_no_commit");
    n_checks++;
    if (data_valid[0] !== 1'b0 || ctrl_data[31:0] !== 32'h00FF8010)
      $display("FAIL filter_hold: got dv %b data %h, expected 0 00ff8010", data_valid[0], ctrl_data[31:0]);
    else n_pass++;
    build_frame(0, 8'h01, 32'h12345678, 8, k);
    expect_commit(0, 32'h12345678);
    play(WMAX);
    check_empty("filter_followup");
  endtask

  task automatic test_overrun();
    int k;
    ack_pulse(4'b0001);
    build_frame(0, 8'h01, 32'hA5A50001, 8, k);
    expect_commit(0, 32'hA5A50001);
    play(WMAX);
    build_frame(0, 8'h01, 32'hA5A50002, 8, k);
    expect_commit(0, 32'hA5A50002);
    play(WMAX);
    check_empty("overrun_two");
    n_checks++;
    if (data_valid[0] !== 1'b1 || overrun[0] !== 1'b1)
      $display("FAIL overrun_set: got dv %b ovr %b, expected 1 1", data_valid[0], overrun[0]);
    else n_pass++;
    build_frame(0, 8'h01, 32'hA5A50003, 8, k);
    ackw[0][k+2] = 1'b1;   // lands on the commit edge
    expect_commit(0, 32'hA5A50003);
    play(WMAX);
    check_empty("overrun_ack_commit");
    n_checks++;
    if (data_valid[0] !== 1'b1 || overrun[0] !== 1'b1)
      $display("FAIL overrun_same_cycle: got dv %b ovr %b, expected 1 1", data_valid[0], overrun[0]);
    else n_pass++;
    ack_pulse(4'b0001);
    n_checks++;
    if (data_valid[0] !== 1'b0 || overrun[0] !== 1'b0)
      $display("FAIL overrun_lone_ack: got dv %b ovr %b, expected 0 0", data_valid[0], overrun[0]);
    else n_pass++;
  endtask

  task automatic test_abort_and_ferr();
    int k;
    int fe0;
    logic [31:0] r;
    fe0 = fe_cnt[0];
    r = 32'hFFFFFFFF;
    add_cmd(0, 8'h01);
    for (int i = 0; i <= 12; i++) add_bit(0, r[i]);
    add(0, 1'b0, 80);      // line stuck low 20 us
    add(0, 1'b1, 8);
    play(WMAX);
    check_empty("abort_no_commit");
    n_checks++;
    if (fe_cnt[0] != fe0 || dbg_state[2:0] !== 3'd0)
      $display("FAIL abort_idle: got ferr %0d state %0d, expected 0 0", fe_cnt[0] - fe0, dbg_state[2:0]);
    else n_pass++;
    build_frame(0, 8'h01, 32'h0BADF00D, 8, k);
    expect_commit(0, 32'h0BADF00D);
    play(WMAX);
    check_empty("abort_recover");
    build_frame(0, 8'h01, 32'h11112222, 1, k);
    play(WMAX);
    check_empty("ferr_no_commit");
    n_checks++;
    if (fe_cnt[0] != fe0 + 1)
      $display("FAIL ferr_pulse: got %0d pulses, expected 1", fe_cnt[0] - fe0);
    else n_pass++;
    n_checks++;
    if (ctrl_data[31:0] !== 32'h0BADF00D)
      $display("FAIL ferr_hold: got %h, expected 0badf00d", ctrl_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_igr();
    int k;
    int igr0;
    logic [31:0] seq [8];
    seq = '{32'h00013030, 32'h00023030, 32'h00033030, 32'h00043030,
            32'h00050000, 32'h00063030, 32'h00073030, 32'h00083030};
    ack_pulse(4'b0001);
    igr_en = 1'b1;
    igr0 = igr_cnt[0];
    for (int f = 0; f < 8; f++) begin
      build_frame(0, 8'h01, seq[f], 8, k);
      expect_commit(0, seq[f]);
      play(WMAX);
      ack_pulse(4'b0001);
    end
    check_empty("igr_frames");
    n_checks++;
    if (igr_cnt[0] - igr0 != 2)
      $display("FAIL igr_count: got %0d pulses, expected 2", igr_cnt[0] - igr0);
    else n_pass++;
    igr_en = 1'b0;
  endtask

  task automatic test_multi_reset();
    int k;
    logic [RB-1:0] d1 [NUM_CH];
    logic [RB-1:0] d3 [NUM_CH];
    ack_pulse('1);
    for (int c = 0; c < NUM_CH; c++) begin
      d1[c] = 32'h11111111 * (c + 1);
      d3[c] = 32'hC0DE0000 | 32'(c * 32'h0101 + 32'h0010);
      add(c, 1'b1, c * 3);
      build_frame(c, 8'h01, d1[c], 8, k);
      expect_commit(c, d1[c]);
    end
    play(WMAX);
    check_empty("multi_round1");
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (ctrl_data[c*RB +: RB] !== d1[c])
        $display("FAIL multi_slice1 ch%0d: got %h, expected %h", c, ctrl_data[c*RB +: RB], d1[c]);
      else n_pass++;
    end
    // second round is cut by reset in the middle of the response
    for (int c = 0; c < NUM_CH; c++) begin
      add(c, 1'b1, c * 3);
      build_frame(c, 8'h01, ~d1[c], 8, k);
    end
    play(300);
    @(negedge clk);
    srst = 1'b1; ctrl = '1; ack = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("midframe_reset");
    srst = 1'b0;
    clear_prev();
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      build_frame(c, 8'h01, d3[c], 8, k);
      expect_commit(c, d3[c]);
    end
    play(WMAX);
    check_empty("multi_round3");
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (ctrl_data[c*RB +: RB] !== d3[c] || data_valid[c] !== 1'b1)
        $display("FAIL multi_slice3 ch%0d: got %h dv %b, expected %h 1",
                 c, ctrl_data[c*RB +: RB], data_valid[c], d3[c]);
      else n_pass++;
    end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overrun();
    test_abort_and_ferr();
    test_igr();
    test_multi_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/n64_joybus_sniffer.md
Name: n64_joybus_sniffer

Overview:
- Multi-port passive sniffer for the N64 joybus.
- Each channel decodes host command bits and controller response bits from its open-drain CTRL line. The controller response is captured only when the command matches a configurable filter.
- Each captured frame is presented with a per-channel valid/ack handshake, and the block detects a configurable in-game-reset button combo held for N consecutive polls.
- Sits in the controller domain between the board CTRL pins and the CPU/PPU config path. It is the multi-channel, handshaked successor of the single-port sniffer.

Parameters:
- NUM_CH, 1, number of independent joybus channels (1..4)
- CNT_W, 6, width of per-channel saturating edge-interval counter; idle/timeout threshold = 2^CNT_W-1 cycles
- CMD_FILTER, 8'h01, host command byte whose response is captured (compared MSB-first)
- RESP_BITS, 32, response data bits captured per frame (8..32)
- STOP_MIN, 4, minimum low width in cycles of the controller stop bit for a valid frame
- IGR_COMBO, 16'h3030, value of response bits [15:0] that forms the reset combo
- IGR_HOLD, 3, consecutive matching committed frames required to fire IGR_TRIG (1..15)

Ports:
- CLK_4M  in  1  sample clock, 4 MHz nominal
- SRST  in  1  asynchronous active-high reset
- CTRL  in  NUM_CH  raw joybus lines, asynchronous
- IGR_EN  in  1  enables combo detection (level, sampled each cycle)
- ACK  in  NUM_CH  per-channel consume strobe for CTRL_DATA
- CTRL_DATA  out  NUM_CH*RESP_BITS  last committed response per channel; channel c at [c*RESP_BITS +: RESP_BITS]
- DATA_VALID  out  NUM_CH  sticky new-data flag per channel
- OVERRUN  out  NUM_CH  sticky: commit occurred while DATA_VALID was set
- FRAME_ERR  out  NUM_CH  1-cycle pulse on stop-bit violation
- IGR_TRIG  out  NUM_CH  1-cycle pulse when combo is held IGR_HOLD polls

Behaviour:
- Reset (async, SRST=1): all outputs 0. Per-channel history = 3'b111. Interval counter = 0. FSM = IDLE. Bit count = 0. Shift register = 0. IGR hold count = 0.
- Input path: 3-bit history per channel, hist <= {hist[1:0],CTRL[c]}. negedge = hist[2]&!hist[1]; posedge = !hist[2]&hist[1].
- Interval counter cnt:
  - cleared on either edge, else increments, saturating at all-ones.
  - Saturation in any state other than IDLE aborts to IDLE with no commit and no FRAME_ERR.
- low_w: latched from cnt on every posedge. Bit decision at the next negedge: bit = (low_w < cnt), i.e. low time shorter than high time means 1.
- FSM per channel (states IDLE, CMD, GAP, RESP, STOP):
  - IDLE: on negedge with cnt saturated -> CMD; bitcnt=0, shift=0.
  - CMD: each negedge with bitcnt<8 shifts the decided bit into cmd, MSB first (bit 0 sampled is the first command bit's value at the 2nd negedge); bitcnt++. Negedge with bitcnt==8 (host stop bit start): cmd==CMD_FILTER -> GAP, else -> IDLE.
  - GAP: next negedge (response bit 0 start) -> RESP; bitcnt=0, no sample.
  - RESP: each negedge shifts the decided bit in LSB-first: shift <= {bit, shift[RESP_BITS-1:1]}, so the first response bit lands at bit 0; bitcnt++. When bitcnt reaches RESP_BITS -> STOP (that negedge is the stop-bit start).
  - STOP: on posedge, if cnt+1 >= STOP_MIN, commit, else pulse FRAME_ERR; both -> IDLE. A negedge in STOP -> IDLE with FRAME_ERR.
- Commit (one cycle, same edge as the stop posedge is detected):
  - CTRL_DATA slice <= shift; DATA_VALID[c] <= 1.
  - OVERRUN[c] <= 1 if DATA_VALID[c] was already 1.
- Handshake:
  - ACK[c] clears DATA_VALID[c] and OVERRUN[c].
  - Commit and ACK in the same cycle: DATA_VALID stays 1; OVERRUN gets the commit rule, evaluated against the pre-ACK value.
  - CTRL_DATA holds until the next commit.
- IGR, evaluated only on commit:
  - IGR_EN=0: hold count = 0.
  - shift[15:0]==IGR_COMBO: hold count increments, saturating at IGR_HOLD. IGR_TRIG pulses on the commit where the count becomes IGR_HOLD. No retrigger until a non-matching frame resets the count to 0.
- Channels are fully independent; simultaneous events on different channels never interact.
- SRST mid-frame: frame is discarded. The first post-reset frame needs a full idle interval (cnt saturate) before capture.

Test Plan:
- Ch0, idle 20 us, host 0x01 + stop, response 32'h00FF8010 + 2 us stop -> CTRL_DATA[31:0]=32'h00FF8010; DATA_VALID[0]=1 one cycle after the stop posedge; FRAME_ERR=0.
- Host command 0x00, then a response frame -> DATA_VALID stays 0, CTRL_DATA unchanged. A follow-up 0x01 poll captures normally.
- Two commits without ACK -> OVERRUN=1 and data = second frame. ACK in the same cycle as a third commit -> DATA_VALID=1, OVERRUN=1. Lone ACK -> both 0.
- Line held low 20 us after response bit 12 -> FSM returns to IDLE, no commit, no FRAME_ERR. Next valid frame captured. Stop low of 1 cycle -> FRAME_ERR pulse, no commit.
- IGR_EN=1, IGR_HOLD=3, three consecutive frames with [15:0]=IGR_COMBO -> one IGR_TRIG pulse on the third commit. A fourth matching frame gives no pulse. Non-matching, then 3 matching -> pulse again.
- NUM_CH=4, all channels polled concurrently with distinct data, SRST asserted mid-frame on the second round -> each slice carries its own data. After reset all outputs are 0 and the next full frame per channel is captured.
